// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stall vector layout and sequencer state encodings
package pipe_ctrl_pkg;

  localparam int STALL_WIDTH = 4;
  localparam int STALL_PC    = 0;
  localparam int STALL_IF    = 1;
  localparam int STALL_ID    = 2;
  localparam int STALL_EX    = 3;

  localparam int REG_ADDR_W  = 5;

  localparam logic [STALL_WIDTH-1:0] STALL_NONE  = '0;
  localparam logic [STALL_WIDTH-1:0] STALL_ALL   = '1;
  localparam logic [STALL_WIDTH-1:0] STALL_FRONT =
    STALL_WIDTH'((1 << STALL_PC) | (1 << STALL_IF) | (1 << STALL_ID));

  typedef enum logic [1:0] {
    PC_S_IDLE      = 2'd0,
    PC_S_INT_WAIT  = 2'd1,
    PC_S_INT_FLUSH = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_haz.sv
// rtl/pipe_ctrl_haz.sv - load-use hazard comparator between EX destination and ID sources
module pipe_ctrl_haz
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_is_load_i,
  input  logic                  ex_rd_we_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_waddr_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_raddr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_raddr_i,
  output logic                  luh_o
);

  // x0 is never a real dependency, so a load targeting it cannot stall ID.
  assign luh_o = ex_is_load_i & ex_rd_we_i & (ex_rd_waddr_i != '0) &
                 ((ex_rd_waddr_i == id_rs1_raddr_i) | (ex_rd_waddr_i == id_rs2_raddr_i));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: stall/flush/bubble arbitration and interrupt entry FSM
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int INT_DRAIN_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold_mem_i,
  input  logic                   hold_ex_i,
  input  logic                   jump_req_i,
  input  logic [31:0]            jump_addr_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_rd_we_i,
  input  logic [REG_ADDR_W-1:0]  ex_rd_waddr_i,
  input  logic [REG_ADDR_W-1:0]  id_rs1_raddr_i,
  input  logic [REG_ADDR_W-1:0]  id_rs2_raddr_i,
  input  logic                   int_req_i,
  input  logic [31:0]            int_addr_i,
  output logic [STALL_WIDTH-1:0] stall_o,
  output logic                   flush_o,
  output logic [31:0]            flush_addr_o,
  output logic                   bubble_o,
  output logic                   int_ack_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  localparam int DW = $clog2(INT_DRAIN_MAX + 1);

  pc_state_e             state_q, state_d;
  logic [31:0]           vec_q;
  logic                  vec_en;
  logic [DW-1:0]         drain_q, drain_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  logic                   hold;
  logic                   luh;
  logic [STALL_WIDTH-1:0] stall_raw;
  logic                   flush_raw;
  logic [31:0]            flush_addr_raw;
  logic                   bubble_raw;
  logic                   ack_raw;

  assign hold = hold_mem_i | hold_ex_i;

  pipe_ctrl_haz u_haz (
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_we_i     (ex_rd_we_i),
    .ex_rd_waddr_i  (ex_rd_waddr_i),
    .id_rs1_raddr_i (id_rs1_raddr_i),
    .id_rs2_raddr_i (id_rs2_raddr_i),
    .luh_o          (luh)
  );

  always_comb begin
    stall_raw      = STALL_NONE;
    flush_raw      = 1'b0;
    flush_addr_raw = '0;
    bubble_raw     = 1'b0;
    ack_raw        = 1'b0;
    if (hold) begin
      stall_raw = STALL_ALL;
    end else if (jump_req_i) begin
      flush_raw      = 1'b1;
      flush_addr_raw = jump_addr_i;
    end else if (state_q == PC_S_INT_FLUSH) begin
      flush_raw      = 1'b1;
      flush_addr_raw = vec_q;
      ack_raw        = 1'b1;
    end else if (luh || (state_q == PC_S_INT_WAIT)) begin
      stall_raw  = STALL_FRONT;
      bubble_raw = 1'b1;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign stall_o      = rst_n ? stall_raw      : STALL_NONE;
  assign flush_o      = rst_n ? flush_raw      : 1'b0;
  assign flush_addr_o = rst_n ? flush_addr_raw : 32'd0;
  assign bubble_o     = rst_n ? bubble_raw     : 1'b0;
  assign int_ack_o    = rst_n ? ack_raw        : 1'b0;
  assign stall_cnt_o  = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    vec_en  = 1'b0;
    case (state_q)
      PC_S_IDLE: begin
        if (int_req_i) begin
          state_d = PC_S_INT_WAIT;
          vec_en  = 1'b1;
          drain_d = '0;
        end
      end
      PC_S_INT_WAIT: begin
        if (!int_req_i) begin
          state_d = PC_S_IDLE;
        end else if (!hold && !jump_req_i) begin
          state_d = PC_S_INT_FLUSH;
        end else if (!hold && (drain_q == DW'(INT_DRAIN_MAX))) begin
          state_d = PC_S_INT_FLUSH;
        end else if (drain_q != DW'(INT_DRAIN_MAX)) begin
          drain_d = drain_q + DW'(1);
        end
      end
      PC_S_INT_FLUSH: begin
        // Leave only once the vector flush has really been issued.
        if (ack_raw) state_d = PC_S_IDLE;
      end
      default: state_d = PC_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PC_S_IDLE;
      vec_q       <= '0;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (vec_en) vec_q <= int_addr_i;
      if (stall_raw[STALL_PC]) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule
